// File: rtl/periph_bus_master.sv
// Bus initiator for the peripheral register block: one READ/WRITE/POLL per command, one response each.
// Optional POLL timeout is enabled by defining POLL_TIMEOUT_EN.
module periph_bus_master #(
  parameter int WIDTH      = 64,
  parameter int AW         = 2,
  parameter int POLL_LIMIT = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [WIDTH-1:0] cmd_wdata,
  input  logic [WIDTH-1:0] cmd_mask,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             wen,
  output logic             ren,
  output logic [AW-1:0]    a,
  output logic [WIDTH-1:0] wd,
  input  logic [WIDTH-1:0] rd
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_POLL   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_mask;
  logic             w_poll_match;
  logic             w_poll_timeout;

  function automatic logic f_masked_eq(input logic [WIDTH-1:0] value,
                                       input logic [WIDTH-1:0] ref_value,
                                       input logic [WIDTH-1:0] mask);
    return ((value & mask) == (ref_value & mask));
  endfunction

  assign w_poll_match = f_masked_eq(rd, r_wdata, r_mask);

`ifdef POLL_TIMEOUT_EN
  localparam int CW = $clog2(POLL_LIMIT + 1);
  logic [CW-1:0] r_poll_cnt;

  // The current read is the last allowed one when POLL_LIMIT-1 reads have already missed.
  assign w_poll_timeout = (r_poll_cnt == CW'(POLL_LIMIT - 1));

  // Poll read counter: cleared outside POLL, saturating inside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_poll_cnt <= {CW{1'b0}};
    end else if (r_state != S_POLL) begin
      r_poll_cnt <= {CW{1'b0}};
    end else if (r_poll_cnt != CW'(POLL_LIMIT)) begin
      r_poll_cnt <= r_poll_cnt + CW'(1);
    end else begin
      r_poll_cnt <= r_poll_cnt;
    end
  end
`else
  // Without the timeout build a POLL never expires.
  assign w_poll_timeout = 1'b0 && (POLL_LIMIT > 0);
`endif

  // Command FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wdata   <= {WIDTH{1'b0}};
      r_mask    <= {WIDTH{1'b0}};
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= {WIDTH{1'b0}};
      rsp_err   <= 1'b0;
      wen       <= 1'b0;
      ren       <= 1'b0;
      a         <= {AW{1'b0}};
      wd        <= {WIDTH{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            a         <= cmd_addr;
            r_wdata   <= cmd_wdata;
            r_mask    <= cmd_mask;
            case (cmd_op)
              OP_READ: begin
                ren     <= 1'b1;
                r_state <= S_ACCESS;
              end
              OP_WRITE: begin
                wen     <= 1'b1;
                wd      <= cmd_wdata;
                r_state <= S_ACCESS;
              end
              OP_POLL: begin
                ren     <= 1'b1;
                r_state <= S_POLL;
              end
              default: begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_rdata <= {WIDTH{1'b0}};
                r_state   <= S_RESP;
              end
            endcase
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_ACCESS: begin
          // wen still high here means this was a WRITE, which returns zero data.
          rsp_rdata <= wen ? {WIDTH{1'b0}} : rd;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          wen       <= 1'b0;
          ren       <= 1'b0;
          r_state   <= S_RESP;
        end
        S_POLL: begin
          if (w_poll_match || w_poll_timeout) begin
            rsp_rdata <= rd;
            rsp_err   <= !w_poll_match;
            rsp_valid <= 1'b1;
            ren       <= 1'b0;
            r_state   <= S_RESP;
          end else begin
            ren <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            rsp_valid <= 1'b1;
          end
        end
        default: begin
          wen       <= 1'b0;
          ren       <= 1'b0;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_master.sv
// Directed plus randomized bench for periph_bus_master with a behavioural peripheral and reference model.
module tb_periph_bus_master;
  localparam int WIDTH = 64;
  localparam int AW    = 2;
  localparam int LIMIT = 8;
`ifdef POLL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk, rst_n;
  logic cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, wen, ren;
  logic [1:0] cmd_op;
  logic [AW-1:0] cmd_addr, a;
  logic [WIDTH-1:0] cmd_wdata, cmd_mask, rsp_rdata, wd, rd;

  periph_bus_master #(.WIDTH(WIDTH), .AW(AW), .POLL_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wen(wen), .ren(ren), .a(a), .wd(wd), .rd(rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peripheral: regs 0,1,3 writable; reg 2 is a status register driven by the bench.
  logic [WIDTH-1:0] mem [4];
  logic [WIDTH-1:0] st_lo, st_hi, status;
  int rise_at;
  int wen_cnt = 0, ren_cnt = 0, both_cnt = 0;
  logic [AW-1:0] last_wa, last_ra;
  logic [WIDTH-1:0] last_wd;

  assign status = (ren_cnt >= rise_at) ? st_hi : st_lo;
  assign rd = ren ? ((a == 2'd2) ? status : mem[a]) : 64'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= 64'd0;
    end else if (wen && a != 2'd2) begin
      mem[a] <= wd;
    end
  end

  always @(posedge clk) begin
    if (wen) begin wen_cnt <= wen_cnt + 1; last_wa <= a; last_wd <= wd; end
    if (ren) begin ren_cnt <= ren_cnt + 1; last_ra <= a; end
    if (wen && ren) both_cnt <= both_cnt + 1;
  end

  int tests_run = 0, tests_failed = 0;
  logic [WIDTH-1:0] model_mem [4];
  logic [1:0] addr_pick [3] = '{2'd0, 2'd1, 2'd3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [1:0] addr, input logic [63:0] wdata,
                         input logic [63:0] mask, input int hold,
                         output logic [63:0] rdata, output logic err, output int lat,
                         output int wens, output int rens);
    int n, wen0, ren0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_mask = mask;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_accept_bound", 64'(n < 50), 64'd1);
    wen0 = wen_cnt; ren0 = ren_cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 3000) begin @(negedge clk); lat++; end
    chk("rsp_bound", 64'(lat < 3000), 64'd1);
    rdata = rsp_rdata; err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rdata", rsp_rdata, rdata);
      chk("hold_err", 64'(rsp_err), 64'(err));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("hold_bus", 64'({wen, ren}), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    wens = wen_cnt - wen0; rens = ren_cnt - ren0;
  endtask

  // Expected results come from the model memory and the poll timing rule, not from the DUT.
  task automatic do_rw(input bit is_write, input logic [1:0] ad, input logic [63:0] dat, input int hold);
    logic [63:0] rdata; logic err; int lat, wens, rens;
    run_cmd(is_write ? 2'b01 : 2'b00, ad, dat, 64'd0, hold, rdata, err, lat, wens, rens);
    chk(is_write ? "wr_rdata" : "rd_rdata", rdata, is_write ? 64'd0 : model_mem[ad]);
    chk("rw_err", 64'(err), 64'd0);
    chk("rw_latency", 64'(lat), 64'd2);
    chk("rw_wen_cycles", 64'(wens), is_write ? 64'd1 : 64'd0);
    chk("rw_ren_cycles", 64'(rens), is_write ? 64'd0 : 64'd1);
    if (is_write) begin
      chk("wr_addr", 64'(last_wa), 64'(ad));
      chk("wr_data", last_wd, dat);
      model_mem[ad] = dat;
    end else begin
      chk("rd_addr", 64'(last_ra), 64'(ad));
    end
  endtask

  // d = number of non-matching reads before the status matches.
  task automatic do_poll(input logic [63:0] msk, input logic [63:0] val, input logic [63:0] lo, input int d);
    logic [63:0] rdata, hi, exp_rdata; logic err, exp_err; int lat, wens, rens, exp_reads;
    hi = (lo & ~msk) | (val & msk);
    st_lo = lo; st_hi = hi;
    rise_at = ren_cnt + d;
    if (TO_EN && d + 1 > LIMIT) begin
      exp_reads = LIMIT; exp_err = 1'b1; exp_rdata = lo;
    end else begin
      exp_reads = d + 1; exp_err = 1'b0; exp_rdata = hi;
    end
    run_cmd(2'b10, 2'd2, val, msk, 0, rdata, err, lat, wens, rens);
    chk("poll_rdata", rdata, exp_rdata);
    chk("poll_err", 64'(err), 64'(exp_err));
    chk("poll_ren_cycles", 64'(rens), 64'(exp_reads));
    chk("poll_latency", 64'(lat), 64'(exp_reads + 1));
    chk("poll_wen_cycles", 64'(wens), 64'd0);
    chk("poll_addr", 64'(last_ra), 64'd2);
  endtask

  task automatic do_illegal(input logic [1:0] ad);
    logic [63:0] rdata; logic err; int lat, wens, rens;
    run_cmd(2'b11, ad, 64'hDEAD, 64'hFF, 1, rdata, err, lat, wens, rens);
    chk("ill_err", 64'(err), 64'd1);
    chk("ill_rdata", rdata, 64'd0);
    chk("ill_latency", 64'(lat), 64'd1);
    chk("ill_bus_cycles", 64'(wens + rens), 64'd0);
  endtask

  initial begin
    logic [63:0] msk, val, lo;
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 2'd0;
    cmd_wdata = 64'd0; cmd_mask = 64'd0; rsp_ready = 1'b0;
    st_lo = 64'd0; st_hi = 64'd0; rise_at = 32'h7fffffff;
    for (int i = 0; i < 4; i++) model_mem[i] = 64'd0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_bus", 64'({wen, ren}), 64'd0);
    chk("rst_a_wd", {wd[61:0], a}, 64'd0);
    chk("rst_rsp", {rsp_rdata[62:0], rsp_err}, 64'd0);
    rst_n = 1'b1;
    #1 chk("ready_before_clk", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_clk", 64'(cmd_ready), 64'd1);

    do_rw(1'b1, 2'd0, 64'h5, 0);
    do_rw(1'b0, 2'd0, 64'd0, 0);
    do_rw(1'b1, 2'd1, 64'hA5, 0);
    do_rw(1'b0, 2'd1, 64'd0, 0);
    do_poll(64'h1, 64'h1, 64'h0, 10);
    do_rw(1'b0, 2'd1, 64'd0, 5);
    do_illegal(2'd3);
    if (TO_EN) begin
      do_poll(64'hF0, 64'h30, 64'h00, 1000);
      do_poll(64'h4, 64'h4, 64'h0, LIMIT - 1);
    end
    do_poll(64'hFFFF_0000_0000_FFFF, 64'h1234_5678_9ABC_DEF0, 64'h0, 0);

    for (int it = 0; it < 40; it++) begin
      int kind;
      logic [1:0] ad;
      kind = $urandom_range(0, 9);
      ad = addr_pick[$urandom_range(0, 2)];
      if (kind < 4) begin
        do_rw(1'b0, ad, 64'd0, $urandom_range(0, 2));
      end else if (kind < 7) begin
        do_rw(1'b1, ad, {$urandom, $urandom}, $urandom_range(0, 1));
      end else if (kind < 9) begin
        msk = {$urandom, $urandom};
        if (msk == 64'd0) msk = 64'h1;
        val = {$urandom, $urandom};
        lo = ({$urandom, $urandom} & ~msk) | (~val & msk);
        do_poll(msk, val, lo, $urandom_range(0, 12));
      end else begin
        do_illegal(ad);
      end
    end

    // Reset in the middle of a POLL that would never match.
    st_lo = 64'h0; st_hi = 64'h0; rise_at = 32'h7fffffff;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 2'd2; cmd_wdata = 64'h1; cmd_mask = 64'h1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("mid_accept_bound", 64'(n < 50), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_poll_ren", 64'(ren), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ren", 64'(ren), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    for (int i = 0; i < 4; i++) model_mem[i] = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("post_rst_bus", 64'({wen, ren}), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    do_rw(1'b0, 2'd1, 64'd0, 0);
    do_rw(1'b1, 2'd3, 64'hCAFE, 0);
    do_rw(1'b0, 2'd3, 64'd0, 0);
    chk("never_wen_and_ren", 64'(both_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
